// File: rtl/wb_dual_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant FSM with a cyc-held bus lock,
// combinational routing of the granted master, and a per-strobe ack watchdog.
module wb_dual_master_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic [7:0]  wdog;
  logic        sel1;
  logic        owned;
  logic        m_cyc;
  logic        m_stb;
  logic        tmo;

  // Reset gates the routing so a slave ack arriving during reset is discarded.
  always_comb begin
    sel1  = (state == GNT1);
    owned = (state != IDLE) && !rst;
    m_cyc = owned && (sel1 ? m1_cyc_i : m0_cyc_i);
    m_stb = owned && (sel1 ? m1_stb_i : m0_stb_i);
    tmo   = m_stb && !s_ack_i && (wdog == WDOG_LAST);
  end

  assign s_addr_o  = owned ? (sel1 ? m1_addr_i : m0_addr_i) : 32'd0;
  assign s_data_o  = owned ? (sel1 ? m1_data_i : m0_data_i) : 32'd0;
  assign s_we_o    = owned && (sel1 ? m1_we_i : m0_we_i);
  assign s_sel_o   = owned ? (sel1 ? m1_sel_i : m0_sel_i) : 4'd0;
  assign s_stb_o   = m_stb && !tmo;
  assign s_cyc_o   = m_cyc && !tmo;

  assign m0_ack_o  = owned && !sel1 && s_ack_i;
  assign m1_ack_o  = owned && sel1 && s_ack_i;
  assign m0_data_o = (owned && !sel1) ? s_data_i : 32'd0;
  assign m1_data_o = (owned && sel1) ? s_data_i : 32'd0;
  assign m0_err_o  = tmo && !sel1;
  assign m1_err_o  = tmo && sel1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_nxt = GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
      end
      GNT0: if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b0;
      wdog    <= 8'd0;
      grant_o <= 2'b00;
    end else begin
      state   <= state_nxt;
      grant_o <= {state_nxt == GNT1, state_nxt == GNT0};
      if (state_nxt != state && state_nxt != IDLE)
        last <= (state_nxt == GNT1);
      // Watchdog measures only the current unacknowledged strobe of the current owner.
      if (state_nxt != state || !m_stb || s_ack_i || tmo)
        wdog <= 8'd0;
      else
        wdog <= wdog + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Randomized bench for wb_dual_master_arbiter, checked every cycle against a
// transaction-level ownership model of the arbitration and watchdog rules.
module tb_wb_dual_master_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] maddr [2];
  logic [31:0] mwdat [2];
  logic        mwe   [2];
  logic [3:0]  msel  [2];
  logic        mstb  [2];
  logic        mcyc  [2];
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  // reference model: owner 0 = nobody, 1 = m0, 2 = m1
  int owner;
  int last_served;
  int waited;
  int n_timeouts = 0;
  bit exp_tmo;

  always #5 clk = ~clk;

  wb_dual_master_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(maddr[0]), .m0_data_i(mwdat[0]), .m0_we_i(mwe[0]), .m0_sel_i(msel[0]),
    .m0_stb_i(mstb[0]), .m0_cyc_i(mcyc[0]), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_addr_i(maddr[1]), .m1_data_i(mwdat[1]), .m1_we_i(mwe[1]), .m1_sel_i(msel[1]),
    .m1_stb_i(mstb[1]), .m1_cyc_i(mcyc[1]), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against what the model says the bus should show now.
  task automatic settle_check();
    int   idx;
    bit   on;
    bit   stb;
    logic [31:0] e_addr, e_wdat, e_rd [2];
    logic [3:0]  e_sel;
    logic        e_we, e_stb, e_cyc;
    logic        e_ack [2];
    logic        e_err [2];
    #2;
    on  = (owner != 0) && !rst;
    idx = (owner == 2) ? 1 : 0;
    stb = on && mstb[idx];
    exp_tmo = stb && !s_ack_i && (waited == TIMEOUT - 1);
    e_addr = on ? maddr[idx] : 32'd0;
    e_wdat = on ? mwdat[idx] : 32'd0;
    e_sel  = on ? msel[idx] : 4'd0;
    e_we   = on && mwe[idx];
    e_stb  = stb && !exp_tmo;
    e_cyc  = on && mcyc[idx] && !exp_tmo;
    for (int m = 0; m < 2; m++) begin
      e_ack[m] = on && (idx == m) && s_ack_i;
      e_err[m] = exp_tmo && (idx == m);
      e_rd[m]  = (on && idx == m) ? s_data_i : 32'd0;
    end
    chk("grant", {30'd0, grant_o}, {30'd0, owner == 2, owner == 1});
    chk("s_addr", s_addr_o, e_addr);
    chk("s_data", s_data_o, e_wdat);
    chk("s_sel", {28'd0, s_sel_o}, {28'd0, e_sel});
    chk("s_we", {31'd0, s_we_o}, {31'd0, e_we});
    chk("s_stb", {31'd0, s_stb_o}, {31'd0, e_stb});
    chk("s_cyc", {31'd0, s_cyc_o}, {31'd0, e_cyc});
    chk("m0_ack", {31'd0, m0_ack_o}, {31'd0, e_ack[0]});
    chk("m1_ack", {31'd0, m1_ack_o}, {31'd0, e_ack[1]});
    chk("m0_err", {31'd0, m0_err_o}, {31'd0, e_err[0]});
    chk("m1_err", {31'd0, m1_err_o}, {31'd0, e_err[1]});
    chk("m0_data", m0_data_o, e_rd[0]);
    chk("m1_data", m1_data_o, e_rd[1]);
    if (exp_tmo) n_timeouts++;
  endtask

  // Advance one clock and apply the ownership rules to the inputs seen at that edge.
  task automatic tick();
    int nxt;
    bit stb_now;
    @(posedge clk);
    stb_now = (owner != 0) && mstb[(owner == 2) ? 1 : 0];
    if (rst) begin
      owner = 0; last_served = 0; waited = 0;
    end else begin
      if (owner == 0) begin
        if (mcyc[0] && mcyc[1]) nxt = (last_served == 0) ? 2 : 1;
        else if (mcyc[0])       nxt = 1;
        else if (mcyc[1])       nxt = 2;
        else                    nxt = 0;
      end else if (mcyc[owner - 1]) begin
        nxt = owner;
      end else begin
        nxt = mcyc[2 - owner] ? (3 - owner) : 0;
      end
      if (nxt != owner || !stb_now || s_ack_i || exp_tmo) waited = 0;
      else waited++;
      if (nxt != owner && nxt != 0) last_served = nxt - 1;
      owner = nxt;
    end
    #1;
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      maddr[m] = 32'd0; mwdat[m] = 32'd0; mwe[m] = 1'b0;
      msel[m] = 4'd0; mstb[m] = 1'b0; mcyc[m] = 1'b0;
    end
    s_ack_i = 1'b0; s_data_i = 32'd0;
  endtask

  initial begin
    owner = 0; last_served = 0; waited = 0; exp_tmo = 1'b0;
    rst = 1'b1;
    idle_inputs();
    tick();
    settle_check();
    chk("reset_grant", {30'd0, grant_o}, 32'd0);
    chk("reset_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    tick();

    // first contention after reset goes to m1
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mcyc[m] = 1'b1; mstb[m] = 1'b1; maddr[m] = 32'h100 * (m + 1);
    end
    settle_check();
    tick();
    settle_check();
    chk("first_contention", {30'd0, grant_o}, 32'd2);
    s_ack_i = 1'b1; s_data_i = 32'h1234_5678;
    settle_check();
    tick();
    mcyc[1] = 1'b0; mstb[1] = 1'b0; s_ack_i = 1'b0;
    settle_check();
    tick();
    settle_check();
    chk("handover_to_m0", {30'd0, grant_o}, 32'd1);
    tick();

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      for (int m = 0; m < 2; m++) begin
        if (mcyc[m]) mcyc[m] = ($urandom_range(0, 5) != 0);
        else         mcyc[m] = ($urandom_range(0, 2) == 0);
        mstb[m]  = mcyc[m] && ($urandom_range(0, 3) != 0);
        maddr[m] = $urandom;
        mwdat[m] = $urandom;
        mwe[m]   = $urandom_range(0, 1);
        msel[m]  = 4'($urandom_range(0, 15));
      end
      s_ack_i  = ($urandom_range(0, 9) < 3);
      s_data_i = $urandom;
      settle_check();
      tick();
    end

    if (n_timeouts == 0) begin
      errors++;
      $display("FAIL timeout_coverage got 0 expected nonzero");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_dual_master_arbiter.md
# wb_dual_master_arbiter

Two-master, one-slave Wishbone arbiter that lets the CPU's instruction-fetch bus interface (master 0) and data-access bus interface (master 1) share a single Wishbone slave port. The arbiter sits between the two bus-interface instances in the core and the external memory/peripheral bus. It sequences ownership with a registered grant FSM, round-robin fairness and bus locking for the duration of `cyc`. A per-transfer watchdog terminates slave accesses that never acknowledge.

## Interface
Parameters:
- TIMEOUT, 255: cycles a granted strobe may wait for `s_ack_i` before forced termination; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- m0_addr_i / m1_addr_i  in  32  master address
- m0_data_i / m1_data_i  in  32  master write data
- m0_we_i / m1_we_i  in  1  write enable
- m0_sel_i / m1_sel_i  in  4  byte selects
- m0_stb_i / m1_stb_i  in  1  strobe
- m0_cyc_i / m1_cyc_i  in  1  cycle; also acts as the bus request
- m0_data_o / m1_data_o  out  32  read data to master
- m0_ack_o / m1_ack_o  out  1  transfer acknowledge
- m0_err_o / m1_err_o  out  1  timeout termination pulse
- s_addr_o, s_data_o  out  32  to slave
- s_we_o  out  1; s_sel_o  out  4; s_stb_o  out  1; s_cyc_o  out  1
- s_data_i  in  32; s_ack_i  in  1  from slave
- grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 2'b00 when idle

## Operation
- Clock `clk`; reset is synchronous, active-high `rst`.
- FSM states: IDLE, GNT0, GNT1. Registers: state, priority pointer `last` (the master served most recently), and 8-bit watchdog counter `wdog`.
- IDLE: if exactly one `mX_cyc_i` = 1, go to GNTX. If both = 1, grant the master not equal to `last`. If none, stay.
- GNTX: hold the grant while `mX_cyc_i` = 1 (bus lock; multiple strobes are allowed). When `mX_cyc_i` = 0, grant the other master directly if its `cyc` = 1; otherwise go to IDLE.
- On every entry to GNTX, set `last` := X.
- Routing in GNTX (combinational): `s_*_o` = `mX_*_i`; `mX_ack_o` = `s_ack_i`; `mX_data_o` = `s_data_i`.
- The non-granted master sees `ack` = 0, `err` = 0 and `data_o` = 0.
- In IDLE, all `s_*_o` = 0 and `grant_o` = 2'b00.
- Watchdog behaviour:
  - In GNTX, `wdog` increments each cycle with `s_stb_o` & ~`s_ack_i`.
  - `wdog` clears on `s_ack_i`, on strobe low, or on any state change.
  - When `wdog` == TIMEOUT-1 and `s_ack_i` = 0, that cycle asserts `mX_err_o` = 1, forces `s_stb_o` = `s_cyc_o` = 0 and `mX_ack_o` = 0, and clears `wdog`.
  - The grant remains until the master drops `cyc`.
- `s_ack_i` arriving in the same cycle as the timeout condition wins: ack is delivered and err stays 0.
- Reset state:
  - `state` = IDLE; `last` = m0, so m1 (data) wins the first contention; `wdog` = 0.
  - All outputs 0, including `grant_o`, acks, errs and `s_*_o`.
- `rst` asserted mid-transfer: the next edge returns to reset state regardless of `cyc`/`ack`. Slave signals drop that cycle, and a pending slave ack is discarded.

## Timing
- Arbitration latency is 1 cycle: a `cyc` rise in cycle N (IDLE) gives `grant_o` and `s_cyc_o`/`s_stb_o` valid in cycle N+1.
- Ack and read data pass through combinationally with zero added latency.
- Handover takes 1 cycle: if the granted master drops `cyc` in cycle N while the other requests, the other owns the bus in N+1, with no IDLE cycle.
- Single request after release: the bus is IDLE for 1 cycle, then grants in the next.
- Timeout: with the strobe held, err is asserted in the TIMEOUT-th waiting cycle (counting the first waiting cycle as 1).

## Test plan
- **Single master:** reset; m0 read at 0x0000_0100, cyc/stb high at cycle 1 → `grant_o` = 01 and `s_addr_o` = 0x100 at cycle 2. Slave acks at cycle 3 with 0x1234_5678 → `m0_ack_o` = 1 and `m0_data_o` = 0x1234_5678 that cycle; `m1_ack_o` = 0.
- **First contention:** both masters raise cyc in the same cycle after reset → m1 granted first (`grant_o` = 10). m1 drops cyc after ack → m0 granted the next cycle, no IDLE cycle in between.
- **Round robin:** both request continuously, with the slave acking each strobe after 1 cycle and masters dropping cyc after ack → grants alternate 10, 01, 10, 01.
- **Bus lock:** m0 holds cyc across 3 strobes while m1 requests → `grant_o` stays 01 until m0 cyc falls; m1 is granted 1 cycle later.
- **Timeout:** TIMEOUT = 4; m1 write, slave never acks → `m1_err_o` pulses 1 for one cycle in the 4th waiting cycle, with `s_stb_o` = 0 that cycle. A repeat with ack arriving in that same cycle → ack = 1 and err = 0.
- **Reset mid-transfer:** assert `rst` while m0 is granted and the strobe is pending → the next cycle has `grant_o` = 00 and all `s_*_o` = 0. After `rst` deasserts with both masters requesting, m1 is granted.
